// File: rtl/enc_16to4_pending_if.sv
// Request/grant bundle for the sequential 16-to-4 pending encoder.
// master: event sources plus consumer; slave: the encoder itself.
interface enc_16to4_pending_if #(
   parameter int unsigned W = 4
);
   localparam int unsigned N = 1 << W;

   logic         en;
   logic [N-1:0] req;
   logic         ack;
   logic         ovf_clr;
   logic [W-1:0] o;
   logic         valid;
   logic [N-1:0] pend;
   logic         ovf;

   modport master (
      output en, req, ack, ovf_clr,
      input  o, valid, pend, ovf
   );

   modport slave (
      input  en, req, ack, ovf_clr,
      output o, valid, pend, ovf
   );
endinterface

// File: rtl/enc_16to4_pending.sv
// Sticky pending register with one-at-a-time encoded presentation and valid/ack handshake.
// Define PRIO_RR_EN for round-robin selection; otherwise the lowest pending index wins.
module enc_16to4_pending #(
   parameter int unsigned W = 4
) (
   input logic                clk,
   input logic                rst,
   enc_16to4_pending_if.slave bus
);
   localparam int unsigned N = 1 << W;

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t       state, state_nx;
   logic [N-1:0] p, p_nx, clr, set;
   logic [W-1:0] o_q, o_nx, sel, idx;
   logic         valid_q, valid_nx;
   logic         ovf_q, ovf_nx;
   logic         accept;

   assign accept = (state == PRESENT) && bus.ack;
   assign set    = bus.en ? bus.req : '0;

   always_comb begin
      clr = '0;
      if (accept) clr[o_q] = 1'b1;
   end

   // A bit set and cleared on the same edge stays pending, and only counts as
   // an overflow when it is not the one being retired.
   assign p_nx   = (p & ~clr) | set;
   assign ovf_nx = (|(set & p & ~clr)) | (ovf_q & ~bus.ovf_clr);

`ifdef PRIO_RR_EN
   logic [W-1:0] ptr;
   logic         found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         ptr <= '1;
      else if (accept) ptr <= o_q;
   end

   // Search starts one past the last accepted index and wraps; ptr itself is tried last.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ptr + W'(i + 1);
         if (!found && p[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end
`else
   // Scan high to low so the lowest set index is the final assignment.
   always_comb begin
      sel = '0;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = W'(N - 1 - i);
         if (p[idx]) sel = idx;
      end
   end
`endif

   always_comb begin
      state_nx = state;
      o_nx     = o_q;
      valid_nx = valid_q;
      case (state)
         IDLE: begin
            if (|p) begin
               o_nx     = sel;
               valid_nx = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               valid_nx = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         p       <= '0;
         o_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         p       <= p_nx;
         o_q     <= o_nx;
         valid_q <= valid_nx;
         ovf_q   <= ovf_nx;
      end
   end

   assign bus.o     = o_q;
   assign bus.valid = valid_q;
   assign bus.pend  = p;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_enc_16to4_pending.sv
// Self-checking bench for enc_16to4_pending: table-driven bursts with a grant
// scoreboard, plus hand-written handshake, overflow and reset sequences.
module tb_enc_16to4_pending;
   logic clk = 1'b0;
   logic rst;

   enc_16to4_pending_if #(.W(4)) bus ();

   enc_16to4_pending #(.W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] req;
      logic        en;
      int unsigned n_grants;
   } vec_t;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  ptr_m;
   vec_t        vecs[7];
   logic [3:0]  exp5[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.req     = '0;
      bus.en      = 1'b1;
      bus.ack     = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 4'hF;
      exp_q.delete();
   endtask

   // Expected grant order for a burst captured while idle.
   function automatic void push_order(input logic [15:0] r);
      logic [3:0] k4;
`ifdef PRIO_RR_EN
      for (int k = 1; k <= 16; k++) begin
         k4 = 4'(ptr_m + 4'(k));
         if (r[k4]) exp_q.push_back(k4);
      end
`else
      for (int k = 0; k < 16; k++) begin
         k4 = 4'(k);
         if (r[k4]) exp_q.push_back(k4);
      end
`endif
   endfunction

   task automatic run_vec(input vec_t v);
      int unsigned got;
      logic        prev;
      logic [3:0]  e;
      got  = 0;
      prev = 1'b0;
      @(negedge clk);
      bus.req = v.req;
      bus.en  = v.en;
      if (v.en) push_order(v.req);
      @(negedge clk);
      bus.req = '0;
      bus.en  = 1'b1;
      bus.ack = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (prev) check("bubble_after_grant", bus.valid, 0);
         if (bus.valid) begin
            got++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_grant: got o=%0d, expected no grant (t=%0t)", bus.o, $time);
            end else begin
               e = exp_q.pop_front();
               check("grant_o", bus.o, e);
               ptr_m = e;
            end
         end
         prev = bus.valid;
      end
      bus.ack = 1'b0;
      check("grant_count", got, v.n_grants);
      check("pend_drained", bus.pend, 0);
      check("valid_idle", bus.valid, 0);
      check("ovf_quiet", bus.ovf, 0);
      exp_q.delete();
   endtask

   initial begin
      int unsigned g;

      vecs[0] = '{req: 16'h0020, en: 1'b1, n_grants: 1};
      vecs[1] = '{req: 16'h8021, en: 1'b1, n_grants: 3};
      vecs[2] = '{req: 16'hFFFF, en: 1'b0, n_grants: 0};
      vecs[3] = '{req: 16'h0001, en: 1'b1, n_grants: 1};
      vecs[4] = '{req: 16'h8000, en: 1'b1, n_grants: 1};
      vecs[5] = '{req: 16'hA5A5, en: 1'b1, n_grants: 8};
      vecs[6] = '{req: 16'h0300, en: 1'b1, n_grants: 2};
`ifdef PRIO_RR_EN
      exp5 = '{4'd0, 4'd3, 4'd0, 4'd3};
`else
      exp5 = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif

      // reset state
      rst = 1'b1;
      idle_inputs();
      #1;
      check("rst_o", bus.o, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_pend", bus.pend, 0);
      check("rst_ovf", bus.ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 4'hF;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // single request: latency, hold while ack=0, one-cycle ack
      do_reset();
      bus.req = 16'h0020;
      @(negedge clk);
      bus.req = '0;
      check("t1_pend_set", bus.pend, 16'h0020);
      check("t1_valid_early", bus.valid, 0);
      @(negedge clk);
      check("t1_valid", bus.valid, 1);
      check("t1_o", bus.o, 5);
      repeat (3) begin
         @(negedge clk);
         check("t1_hold_valid", bus.valid, 1);
         check("t1_hold_o", bus.o, 5);
      end
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      check("t1_valid_after_ack", bus.valid, 0);
      check("t1_pend_after_ack", bus.pend, 0);

      // enable off
      do_reset();
      bus.en  = 1'b0;
      bus.req = 16'hFFFF;
      repeat (10) @(negedge clk);
      idle_inputs();
      check("t3_pend", bus.pend, 0);
      check("t3_valid", bus.valid, 0);
      check("t3_ovf", bus.ovf, 0);

      // re-request during ack, then overflow
      do_reset();
      bus.req = 16'h0004;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      check("t4_o", bus.o, 2);
      bus.ack = 1'b1;
      bus.req = 16'h0004;
      @(negedge clk);
      bus.ack = 1'b0;
      bus.req = '0;
      check("t4_pend_set_wins", bus.pend, 16'h0004);
      check("t4_ovf_not_set", bus.ovf, 0);
      check("t4_bubble", bus.valid, 0);
      @(negedge clk);
      check("t4_re_valid", bus.valid, 1);
      check("t4_re_o", bus.o, 2);
      bus.req = 16'h0004;
      @(negedge clk);
      bus.req = '0;
      check("t4_ovf_set", bus.ovf, 1);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      check("t4_ovf_clr", bus.ovf, 0);
      bus.req     = 16'h0004;
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.req     = '0;
      bus.ovf_clr = 1'b0;
      check("t4_ovf_set_beats_clr", bus.ovf, 1);
      bus.ovf_clr = 1'b1;
      bus.ack     = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      bus.ack     = 1'b0;
      check("t4_ovf_clr2", bus.ovf, 0);
      check("t4_pend_final", bus.pend, 0);

      // reset mid-handshake
      do_reset();
      bus.req = 16'h0110;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      check("t6_valid", bus.valid, 1);
      check("t6_o", bus.o, 4);
      bus.req = 16'h0110;
      @(negedge clk);
      bus.req = '0;
      check("t6_pend", bus.pend, 16'h0110);
      check("t6_ovf_pre", bus.ovf, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_o", bus.o, 0);
      check("t6_rst_valid", bus.valid, 0);
      check("t6_rst_pend", bus.pend, 0);
      check("t6_rst_ovf", bus.ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.req = 16'h0100;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      check("t6_post_valid", bus.valid, 1);
      check("t6_post_o", bus.o, 8);
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      check("t6_post_pend", bus.pend, 0);

      // priority under sustained load
      do_reset();
      bus.req = 16'h0009;
      bus.ack = 1'b1;
      g = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.valid && g < 4) begin
            check("t5_grant_o", bus.o, exp5[g]);
            g++;
         end
      end
      check("t5_grant_count", g, 4);
      check("t5_ovf", bus.ovf, 1);
      bus.req = '0;
      repeat (8) @(negedge clk);
      bus.ack = 1'b0;
      check("t5_pend_drained", bus.pend, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
